// File: rtl/tile_pkg.sv
// Shared definitions for the tile board generator: code field layout,
// board size, base colour table, FSM states and the read-port encoder.
package tile_pkg;

   localparam int TILE_CNT   = 10;
   localparam int IDX_W      = 4;
   localparam int COLOUR_W   = 6;
   localparam int CODE_W     = 11;
   localparam int FLIP_OFF   = 0;
   localparam int COLOUR_OFF = 1;
   localparam int COL_OFF    = 7;
   localparam int ROW_OFF    = 9;

   localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;

   typedef logic [TILE_CNT-1:0][COLOUR_W-1:0] board_t;

   // Slot 9 first, slot 0 last: 1,2,3,4,2,4,3,1,5,5 for slots 0..9.
   localparam board_t BASE_COLOUR = {6'd5, 6'd5, 6'd1, 6'd3, 6'd4,
                                     6'd2, 6'd4, 6'd3, 6'd2, 6'd1};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_PICK,
      ST_SWAP,
      ST_DONE
   } state_e;

   // Out-of-range indices and empty (colour 0) slots both read as all-zero,
   // so a cleared board returns 0 on every index.
   function automatic logic [CODE_W-1:0] tile_code(input logic [IDX_W-1:0] idx,
                                                   input board_t board);
      logic [COLOUR_W-1:0] c;
      tile_code = '0;
      c         = '0;
      if (idx <= LAST_IDX) begin
         c = board[idx];
         if (c != '0) tile_code = {idx[3:2], idx[1:0], c, 1'b0};
      end
   endfunction

endpackage

// File: rtl/tile_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Advances every cycle; reset reloads SEED (must be non-zero).
module tile_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/tile_shuffler.sv
// Ten-tile board generator with two registered read ports. Define
// TILE_SHUFFLE_EN to build the LFSR-driven Fisher-Yates shuffle.
module tile_shuffler
   import tile_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic [IDX_W-1:0]  rd_index_a,
   input  logic [IDX_W-1:0]  rd_index_b,
   output logic [CODE_W-1:0] tile_code_a,
   output logic [CODE_W-1:0] tile_code_b,
   output logic              busy,
   output logic              ready
);

   logic [15:0] lfsr;
   logic        lfsr_unused;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   k_q, k_d;
   board_t             colour_q, colour_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic [CODE_W-1:0]  code_a_q, code_a_d;
   logic [CODE_W-1:0]  code_b_q, code_b_d;

   tile_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (CLOCK_50),
      .reset (reset),
      .lfsr  (lfsr)
   );

`ifdef TILE_SHUFFLE_EN
   logic [IDX_W-1:0] i_q, i_d;
   logic [IDX_W-1:0] j_q, j_d;
   assign lfsr_unused = ^lfsr[15:4];
`else
   assign lfsr_unused = ^lfsr;
`endif

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      colour_d = colour_q;
      busy_d   = busy_q;
      ready_d  = ready_q;
      // Reads see the pre-write board, giving old-data on a same-cycle write.
      code_a_d = tile_code(rd_index_a, colour_q);
      code_b_d = tile_code(rd_index_b, colour_q);
`ifdef TILE_SHUFFLE_EN
      i_d      = i_q;
      j_d      = j_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_FILL;
               k_d     = '0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end
         ST_FILL: begin
            colour_d[k_q] = BASE_COLOUR[k_q];
            k_d           = k_q + 4'd1;
            if (k_q == LAST_IDX) begin
`ifdef TILE_SHUFFLE_EN
               state_d = ST_PICK;
               i_d     = LAST_IDX;
`else
               state_d = ST_DONE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
`endif
            end
         end
`ifdef TILE_SHUFFLE_EN
         ST_PICK: begin
            // Rejection sampling keeps the pick uniform over 0..i.
            if (lfsr[3:0] <= i_q) begin
               j_d     = lfsr[3:0];
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            colour_d[i_q] = colour_q[j_q];
            colour_d[j_q] = colour_q[i_q];
            i_d           = i_q - 4'd1;
            if (i_q == 4'd1) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               state_d = ST_PICK;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         colour_q <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         code_a_q <= '0;
         code_b_q <= '0;
`ifdef TILE_SHUFFLE_EN
         i_q      <= '0;
         j_q      <= '0;
`endif
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         colour_q <= colour_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         code_a_q <= code_a_d;
         code_b_q <= code_b_d;
`ifdef TILE_SHUFFLE_EN
         i_q      <= i_d;
         j_q      <= j_d;
`endif
      end
   end

   assign tile_code_a = code_a_q;
   assign tile_code_b = code_b_q;
   assign busy        = busy_q;
   assign ready       = ready_q;

endmodule

// File: tb/tb_tile_shuffler.sv
// Bench for tile_shuffler: a cycle-level behavioural model (board plan computed
// from the LFSR sequence) checked every cycle, plus literal board checks.
module tb_tile_shuffler;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam int W_IDLE = 2;

   logic        CLOCK_50;
   logic        reset;
   logic        start;
   logic [3:0]  rd_index_a;
   logic [3:0]  rd_index_b;
   logic [10:0] tile_code_a;
   logic [10:0] tile_code_b;
   logic        busy;
   logic        ready;

   tile_shuffler #(.LFSR_SEED(SEED)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .start       (start),
      .rd_index_a  (rd_index_a),
      .rd_index_b  (rd_index_b),
      .tile_code_a (tile_code_a),
      .tile_code_b (tile_code_b),
      .busy        (busy),
      .ready       (ready)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at cycle", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int base_tbl[10] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};

   int          cyc = 0;
   logic [15:0] m_lfsr = SEED;
   int          m_phase = 0;       // 0 idle, 1 generating, 2 done
   bit          m_known = 0;       // board contents defined this cycle
   int          m_brd[10];
   int          pend_brd[10];
   int          pend_t;
   int          ready_at;
   int          exp_a, exp_b;
   bit          exp_vld = 0;
   bit          chk_en = 0;

   function automatic logic [15:0] adv(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic int mcode(input int idx, input int colour);
      if (idx > 9 || colour == 0) return 0;
      return (idx / 4) * 512 + (idx % 4) * 128 + colour * 2;
   endfunction

   // Board and extra cycles after FILL, given the LFSR value in the start cycle.
   task automatic plan_board(input logic [15:0] l_n);
      logic [15:0] v;
      int i, j, tmp;
      v = l_n;
      for (int s = 0; s < 10; s++) pend_brd[s] = base_tbl[s];
      pend_t = 0;
`ifdef TILE_SHUFFLE_EN
      for (int s = 0; s < 11; s++) v = adv(v);
      i = 9;
      while (i > 0) begin
         j = int'(v[3:0]);
         v = adv(v);
         pend_t++;
         if (j <= i) begin
            v = adv(v);
            pend_t++;
            tmp = pend_brd[i]; pend_brd[i] = pend_brd[j]; pend_brd[j] = tmp;
            i--;
         end
      end
`endif
   endtask

   always @(posedge CLOCK_50) begin
      if (reset) begin
         exp_a = 0; exp_b = 0; exp_vld = 1;
      end else begin
         exp_vld = m_known;
         exp_a = (rd_index_a <= 9) ? mcode(int'(rd_index_a), m_brd[rd_index_a]) : 0;
         exp_b = (rd_index_b <= 9) ? mcode(int'(rd_index_b), m_brd[rd_index_b]) : 0;
      end
      cyc++;
      if (reset) begin
         m_lfsr = SEED; m_phase = 0; m_known = 1;
         for (int s = 0; s < 10; s++) m_brd[s] = 0;
      end else begin
         if (start && m_phase != 1) begin
            plan_board(m_lfsr);
            m_phase = 1; m_known = 0;
            ready_at = cyc + 10 + pend_t;
         end else if (m_phase == 1 && cyc == ready_at) begin
            m_phase = 2; m_known = 1;
            for (int s = 0; s < 10; s++) m_brd[s] = pend_brd[s];
         end
         m_lfsr = adv(m_lfsr);
      end
   end

   always @(negedge CLOCK_50) begin
      if (chk_en) begin
         chk("busy", int'(busy), int'(m_phase == 1));
         chk("ready", int'(ready), int'(m_phase == 2));
         if (exp_vld) begin
            chk("code_a", int'(tile_code_a), exp_a);
            chk("code_b", int'(tile_code_b), exp_b);
         end
      end
   end

   // ---------------- stimulus ----------------
   int dut_brd[10];
   int dut_code[10];
   int r1_brd[10];
   int r1_lat;
   int lat;
   int n_start;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         rd_index_a = 4'($urandom_range(0, 15));
         rd_index_b = 4'($urandom_range(0, 15));
         tick();
      end
   endtask

   // One reset edge, then idle checks; identical timing each call so the
   // LFSR phase at the following start is always the same.
   task automatic reset_and_check(input bit with_start);
      reset = 1'b1; start = with_start;
      tick();
      reset = 1'b0; start = 1'b0;
      @(negedge CLOCK_50);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(ready), 0);
      for (int s = 0; s < 10; s++) begin
         rd_index_a = 4'(s);
         rd_index_b = 4'($urandom_range(0, 15));
         tick();
         chk($sformatf("rst_read%0d", s), int'(tile_code_a), 0);
      end
      idle(W_IDLE);
   endtask

   task automatic gen(input int pulse_at, output int l);
      bit seen;
      seen = 0; l = -1;
      start = 1'b1; n_start = cyc;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         if (cyc - n_start == pulse_at) start = 1'b1;
         rd_index_a = 4'($urandom_range(0, 15));
         rd_index_b = 4'($urandom_range(0, 15));
         @(negedge CLOCK_50);
         if (ready) begin
            seen = 1; l = cyc - n_start;
         end
         tick();
         start = 1'b0;
      end
      if (!seen) chk("ready_timeout", 0, 1);
      else       chk("latency_vs_model", l, ready_at - n_start);
   endtask

   task automatic read_board();
      for (int s = 0; s < 10; s++) begin
         rd_index_a = 4'(s);
         rd_index_b = 4'($urandom_range(0, 15));
         tick();
         dut_code[s] = int'(tile_code_a);
         dut_brd[s]  = int'(tile_code_a[6:1]);
      end
   endtask

   task automatic check_counts();
      int cnt[6];
      for (int c = 0; c < 6; c++) cnt[c] = 0;
      for (int s = 0; s < 10; s++)
         if (dut_brd[s] >= 1 && dut_brd[s] <= 5) cnt[dut_brd[s]]++;
         else cnt[0]++;
      chk("colour0_count", cnt[0], 0);
      for (int c = 1; c < 6; c++) chk($sformatf("colour%0d_count", c), cnt[c], 2);
   endtask

   initial begin
      int diff;
      reset = 1'b1; start = 1'b0; rd_index_a = '0; rd_index_b = '0;
      tick();
      chk_en = 1;

      // Run 1: reference board from reset.
      reset_and_check(0);
      gen(-1, lat);
      r1_lat = lat;
`ifdef TILE_SHUFFLE_EN
      chk("lat_at_least_29", int'(lat >= 29), 1);
`else
      chk("lat_is_11", lat, 11);
`endif
      read_board();
      for (int s = 0; s < 10; s++) r1_brd[s] = dut_brd[s];
      for (int s = 0; s < 10; s++) chk($sformatf("run1_slot%0d", s), dut_brd[s], m_brd[s]);
      check_counts();
`ifndef TILE_SHUFFLE_EN
      chk("slot0_code", dut_code[0], 11'h002);
      chk("slot9_code", dut_code[9], 11'h48A);
`endif
      idle(30);

      // Run 2: same timing, extra start pulse mid-generation must be ignored.
      reset_and_check(0);
`ifdef TILE_SHUFFLE_EN
      gen(15, lat);
`else
      gen(5, lat);
`endif
      chk("pulse_latency_same", lat, r1_lat);
      read_board();
      for (int s = 0; s < 10; s++) chk($sformatf("pulse_slot%0d", s), dut_brd[s], r1_brd[s]);

      // Run 3: reset mid-generation (with coincident start), then regenerate.
      start = 1'b1; tick(); start = 1'b0;
`ifdef TILE_SHUFFLE_EN
      idle(19);
`else
      idle(4);
`endif
      reset_and_check(1);
      gen(-1, lat);
      chk("rerun_latency_same", lat, r1_lat);
      read_board();
      for (int s = 0; s < 10; s++) chk($sformatf("rerun_slot%0d", s), dut_brd[s], r1_brd[s]);

      // Out-of-range and mixed reads in DONE.
      rd_index_a = 4'd12; rd_index_b = 4'd3;
      tick();
      chk("oob_read_a", int'(tile_code_a), 0);
      chk("rd3_rowcol", int'(tile_code_b[10:7]), 4'b0011);
      chk("rd3_colour", int'(tile_code_b[6:1]), r1_brd[3]);
      chk("rd3_flip", int'(tile_code_b[0]), 0);
      idle(20);

      // Run 4: start in DONE reshuffles.
      gen(-1, lat);
      read_board();
      check_counts();
      for (int s = 0; s < 10; s++) chk($sformatf("run4_slot%0d", s), dut_brd[s], m_brd[s]);
      diff = 0;
      for (int s = 0; s < 10; s++) if (dut_brd[s] != r1_brd[s]) diff++;
`ifdef TILE_SHUFFLE_EN
      chk("reshuffle_differs", int'(diff > 0), 1);
`else
      chk("board_fixed", diff, 0);
`endif
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
